// File: rtl/dcache_wt_if.sv
// Core-side and backing-memory-side signals of the write-through data cache.
// The cache takes the slave view; whoever drives the core and memory takes the master view.
interface dcache_wt_if;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_dout, bus_rdata, bus_ack,
    output mem_din, mem_stall, bus_req, bus_we, bus_addr, bus_wdata
  );

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_dout, bus_rdata, bus_ack,
    input  mem_din, mem_stall, bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate cache with one-word lines.
// Read hits return the same cycle; misses and all writes stall the core until bus_ack.
module dcache_wt #(
  parameter int IDX_BITS = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  dcache_wt_if.slave       dc,
  input  logic             flush_i,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);
  localparam int LINES = 1 << IDX_BITS;
  localparam int TAG_W = 30 - IDX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_e;

  state_e             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES];
  logic               flush_pend_q, flush_pend_d;
  logic               bus_req_q, bus_req_d;
  logic               bus_we_q, bus_we_d;
  logic [31:0]        bus_addr_q, bus_addr_d;
  logic [31:0]        bus_wdata_q, bus_wdata_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic               line_we;
  logic [31:0]        line_data;
  logic [IDX_BITS-1:0] req_idx, bus_idx;
  logic [TAG_W-1:0]   req_tag, bus_tag;
  logic               req_hit, bus_hit;
  logic               unused_addr_bits;

  assign req_idx = dc.mem_addr[IDX_BITS+1:2];
  assign req_tag = dc.mem_addr[31:IDX_BITS+2];
  // In-flight transactions use the latched bus address, not the core's live address.
  assign bus_idx = bus_addr_q[IDX_BITS+1:2];
  assign bus_tag = bus_addr_q[31:IDX_BITS+2];
  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign bus_hit = valid_q[bus_idx] && (tag_q[bus_idx] == bus_tag);
  assign unused_addr_bits = ^{dc.mem_addr[1:0], bus_addr_q[1:0]};

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    line_we      = 1'b0;
    line_data    = dc.bus_rdata;
    dc.mem_din   = data_q[req_idx];
    dc.mem_stall = 1'b0;

    case (state_q)
      S_IDLE: begin
        flush_pend_d = 1'b0;
        if (dc.mem_wen) begin
          dc.mem_stall = 1'b1;
          state_d      = S_WR;
          bus_req_d    = 1'b1;
          bus_we_d     = 1'b1;
          bus_addr_d   = {dc.mem_addr[31:2], 2'b00};
          bus_wdata_d  = dc.mem_dout;
        end else if (dc.mem_ren) begin
          if (req_hit) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
          end else begin
            dc.mem_stall = 1'b1;
            miss_cnt_d   = miss_cnt_q + CNT_W'(1);
            state_d      = S_RD;
            bus_req_d    = 1'b1;
            bus_we_d     = 1'b0;
            bus_addr_d   = {dc.mem_addr[31:2], 2'b00};
          end
        end
        if (flush_i) valid_d = '0;
      end

      S_RD, S_WR: begin
        dc.mem_stall = 1'b1;
        if (flush_i) flush_pend_d = 1'b1;
        if (dc.bus_ack) begin
          dc.mem_stall = 1'b0;
          state_d      = S_IDLE;
          bus_req_d    = 1'b0;
          if (state_q == S_RD) begin
            dc.mem_din       = dc.bus_rdata;
            line_we          = 1'b1;
            valid_d[bus_idx] = 1'b1;
          end else if (bus_hit) begin
            line_we   = 1'b1;
            line_data = bus_wdata_q;
          end
          // A flush seen during the transaction wipes everything, including this fill.
          if (flush_pend_q || flush_i) valid_d = '0;
          flush_pend_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[bus_idx]  <= bus_tag;
      data_q[bus_idx] <= line_data;
    end
  end

  assign dc.bus_req   = bus_req_q;
  assign dc.bus_we    = bus_we_q;
  assign dc.bus_addr  = bus_addr_q;
  assign dc.bus_wdata = bus_wdata_q;
  assign hit_cnt_o    = hit_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;
endmodule
